window_buffer_stream: RTL and testbench
=======================================

# window_buffer_stream

Parametrised successor of the fixed 4x4 window register for the convolution datapath. Holds a ROWS x COLS window of DW-bit pixels. The window can be filled in three ways: a parallel full load, a column-wise sliding shift for raster scanning, or a synchronous clear. Contents are read either by random-access index or as a registered serial stream with a valid/last handshake toward the MAC stage.

## Interface
Parameters:
- DW, 8, pixel width in bits
- ROWS, 4, window rows (≥1)
- COLS, 4, window columns (≥1)
- N (localparam), ROWS*COLS, element count; IW = max(1, $clog2(N)), index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserts immediately when low, released synchronously by design intent)
- clear  in  1  synchronous clear of window and fill count
- load  in  1  parallel load of full window from inp
- inp  in  N*DW  element (r,c) at bits [(r*COLS+c)*DW +: DW]
- shift  in  1  slide window left one column, col_in enters at column COLS-1
- col_in  in  ROWS*DW  row r at bits [r*DW +: DW]
- index  in  IW  random-access read address, row-major (r*COLS+c)
- outp  out  DW  combinational window[index]; 0 if index ≥ N
- full  out  1  window fully populated since last clear/reset
- rd_start  in  1  request serial readout of whole window
- busy  out  1  stream in progress
- stream_data  out  DW  registered serial element
- stream_valid  out  1  stream_data valid this cycle
- stream_last  out  1  final element (index N-1) of stream

## Operation
- Reset (rst low): all window elements 0, fill_cnt 0, full 0, busy 0, stream_valid 0, stream_last 0, stream_data 0, read pointer 0.
- Window write priority per cycle: clear > load > shift. Writes only occur when the window is not frozen (see below); clear is never blocked.
- clear: all elements 0, fill_cnt 0; aborts any stream (busy, stream_valid, stream_last → 0 next cycle).
- load: window[r][c] ← inp element (r,c); fill_cnt ← COLS.
- shift: window[r][c] ← window[r][c+1] for c < COLS-1; window[r][COLS-1] ← col_in row r; fill_cnt ← min(fill_cnt+1, COLS), saturating.
- full = (fill_cnt == COLS).
- Window is frozen while busy = 1: load and shift are ignored (dropped, not queued) and fill_cnt is unchanged.
- Stream FSM states: IDLE, STREAM.
  - IDLE → STREAM on rd_start (without clear); read pointer ← 0.
  - In STREAM, each cycle emits window[ptr] on the next edge and increments ptr.
  - After emitting ptr = N-1 → IDLE, unless rd_start is high in the stream_last cycle, which restarts at ptr 0 (back-to-back streams).
  - rd_start in STREAM outside the last cycle is ignored.
- outp is purely combinational from current register contents, independent of stream state.

## Timing
- load/shift/clear at edge t: new contents visible on outp after edge t; full updates at the same edge.
- rd_start sampled at edge t: busy, stream_valid = 1 with stream_data = element 0 during cycle t+1. Element k is presented in cycle t+1+k, stream_last in cycle t+N, busy low at t+N+1 unless restarted.
- N = 1: single-cycle stream, stream_valid and stream_last high together.
- Throughput: one element per cycle. Sink has no backpressure; it must accept every valid element.
- clear during STREAM at edge t: stream_valid 0 from cycle t+1; no partial last.
- rst low mid-stream: outputs return to reset values immediately (asynchronously).

## Test plan
- Reset: drive rst low with random prior state, then release → outp = 0 for every index, full = 0, busy = 0, stream_valid = 0.
- Parallel load (defaults): inp element k = k+1 (elements 1..16), load for 1 cycle → outp(index 5) = 6, full = 1; index 15 → 16.
- Sliding fill: after clear, shift 4 times with col_in rows {10r+c} → full rises only after the 4th shift; 5th shift with rows = 0xA0..0xA3 → column 3 = A0..A3, column 0 = former column 1, full stays 1.
- Stream: after loading 1..16, pulse rd_start at t → stream_data 1..16 in cycles t+1..t+16, stream_last only at t+16; load asserted at t+5 is ignored (outp unchanged after stream).
- Priority and back-to-back: load+shift+clear in the same cycle → all elements 0, full = 0; rd_start held during the last cycle → second stream follows with no gap.
- Async reset at stream element 7 → stream_valid 0 immediately, window all 0, and no stream_last is ever emitted.

Source files
------------

// File: rtl/window_buffer_stream_if.sv
// Pixel-window bus: fill controls, random-access read port and serial stream toward the MAC stage.
// The master side drives fills, index and rd_start; the slave side returns pixels, status and the stream.
interface window_buffer_stream_if #(
  parameter int DW   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                 clear;
  logic                 load;
  logic [N*DW-1:0]      inp;
  logic                 shift;
  logic [ROWS*DW-1:0]   col_in;
  logic [IW-1:0]        index;
  logic [DW-1:0]        outp;
  logic                 full;
  logic                 rd_start;
  logic                 busy;
  logic [DW-1:0]        stream_data;
  logic                 stream_valid;
  logic                 stream_last;

  modport master (
    output clear, load, inp, shift, col_in, index, rd_start,
    input  outp, full, busy, stream_data, stream_valid, stream_last
  );

  modport slave (
    input  clear, load, inp, shift, col_in, index, rd_start,
    output outp, full, busy, stream_data, stream_valid, stream_last
  );
endinterface

// File: rtl/window_buffer_stream.sv
// ROWS x COLS pixel window: parallel load, column slide or clear; combinational index read; registered serial stream.
// Stream element 0 appears one cycle after rd_start, one element per cycle, no sink backpressure; window frozen while busy.
module window_buffer_stream #(
  parameter int DW   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  window_buffer_stream_if.slave   io_bus
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(COLS + 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [DW-1:0] r_win [N];
  logic [CW-1:0] r_fill;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [DW-1:0] r_dat, w_dat_nxt;
  logic          r_vld, w_vld_nxt;
  logic          r_last, w_last_nxt;
  logic          w_busy;
  logic          w_start;

  assign w_busy = (r_state == S_STREAM);

  // Window storage; clear always wins, load/shift are dropped while a stream reads the window.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_fill <= '0;
    end else if (io_bus.clear) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_fill <= '0;
    end else if (!w_busy) begin
      if (io_bus.load) begin
        for (int i = 0; i < N; i++) r_win[i] <= io_bus.inp[i*DW +: DW];
        r_fill <= CW'(COLS);
      end else if (io_bus.shift) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS - 1; c++) r_win[r*COLS + c] <= r_win[r*COLS + c + 1];
          r_win[r*COLS + COLS - 1] <= io_bus.col_in[r*DW +: DW];
        end
        if (r_fill != CW'(COLS)) r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_dat   <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dat   <= w_dat_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // A new stream may start from idle or in the last cycle of the current one (back-to-back).
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_dat_nxt   = r_dat;
    w_vld_nxt   = r_vld;
    w_last_nxt  = r_last;
    w_start     = !io_bus.clear && io_bus.rd_start && ((r_state == S_IDLE) || r_last);
    if (io_bus.clear) begin
      w_state_nxt = S_IDLE;
      w_ptr_nxt   = '0;
      w_dat_nxt   = '0;
      w_vld_nxt   = 1'b0;
      w_last_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = S_STREAM;
      w_dat_nxt   = r_win[0];
      w_vld_nxt   = 1'b1;
      w_last_nxt  = (N == 1);
      w_ptr_nxt   = (N == 1) ? '0 : IW'(1);
    end else if (r_state == S_STREAM) begin
      if (r_last) begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
        w_dat_nxt   = '0;
        w_vld_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
      end else begin
        w_dat_nxt   = r_win[r_ptr];
        w_vld_nxt   = 1'b1;
        w_last_nxt  = (r_ptr == IW'(N - 1));
        w_ptr_nxt   = r_ptr + 1'b1;
      end
    end
  end

  assign io_bus.outp         = (int'(io_bus.index) < N) ? r_win[io_bus.index] : '0;
  assign io_bus.full         = (r_fill == CW'(COLS));
  assign io_bus.busy         = w_busy;
  assign io_bus.stream_data  = r_dat;
  assign io_bus.stream_valid = r_vld;
  assign io_bus.stream_last  = r_last;
endmodule

// File: tb/tb_window_buffer_stream.sv
// Directed bench for window_buffer_stream at default 4x4x8 parameters.
module tb_window_buffer_stream;
  localparam int DW = 8, ROWS = 4, COLS = 4, N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   last_seen;

  window_buffer_stream_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS)) bus ();

  window_buffer_stream #(.DW(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_at(input int idx, input logic [31:0] exp, input string tag);
    bus.index = 4'(idx);
    #1;
    check(tag, 32'(bus.outp), exp);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < N; k++) bus.inp[k*DW +: DW] = 8'(k + 1);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.clear = 0; bus.load = 0; bus.shift = 0; bus.rd_start = 0;
    bus.inp = '0; bus.col_in = '0; bus.index = '0;

    // Random prior state, then asynchronous reset.
    tick();
    for (int k = 0; k < N; k++) bus.inp[k*DW +: DW] = 8'($urandom_range(1, 255));
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) read_at(k, 0, "reset_outp");
    check("reset_full", 32'(bus.full), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_valid", 32'(bus.stream_valid), 0);
    check("reset_last", 32'(bus.stream_last), 0);
    check("reset_data", 32'(bus.stream_data), 0);
    tick();
    rst = 1'b1;
    tick();

    // Parallel load.
    load_ramp();
    read_at(5, 6, "load_idx5");
    read_at(15, 16, "load_idx15");
    read_at(0, 1, "load_idx0");
    check("load_full", 32'(bus.full), 1);

    // Clear then sliding fill: shift c carries 10r+c on row r.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clear_full", 32'(bus.full), 0);
    read_at(5, 0, "clear_idx5");
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) bus.col_in[r*DW +: DW] = 8'(10*r + c);
      bus.shift = 1'b1;
      tick();
      bus.shift = 1'b0;
      check("slide_full", 32'(bus.full), (c == COLS - 1) ? 1 : 0);
    end
    read_at(9, 21, "slide_r2c1");
    read_at(15, 33, "slide_r3c3");
    for (int r = 0; r < ROWS; r++) bus.col_in[r*DW +: DW] = 8'(8'hA0 + r);
    bus.shift = 1'b1;
    tick();
    bus.shift = 1'b0;
    read_at(3, 32'hA0, "slide5_r0c3");
    read_at(7, 32'hA1, "slide5_r1c3");
    read_at(15, 32'hA3, "slide5_r3c3");
    read_at(0, 1, "slide5_r0c0");
    read_at(12, 31, "slide5_r3c0");
    read_at(6, 13, "slide5_r1c2");
    check("slide5_full", 32'(bus.full), 1);

    // Stream 1..16 with a load at t+5 that must be dropped.
    load_ramp();
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    check("str_busy0", 32'(bus.busy), 1);
    check("str_valid0", 32'(bus.stream_valid), 1);
    check("str_data0", 32'(bus.stream_data), 1);
    check("str_last0", 32'(bus.stream_last), 0);
    for (int k = 1; k < N; k++) begin
      if (k == 5) begin
        for (int j = 0; j < N; j++) bus.inp[j*DW +: DW] = 8'h77;
        bus.load = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      check("str_valid", 32'(bus.stream_valid), 1);
      check("str_data", 32'(bus.stream_data), 32'(k + 1));
      check("str_last", 32'(bus.stream_last), (k == N - 1) ? 1 : 0);
    end
    tick();
    check("str_end_busy", 32'(bus.busy), 0);
    check("str_end_valid", 32'(bus.stream_valid), 0);
    check("str_end_last", 32'(bus.stream_last), 0);
    read_at(5, 6, "str_frozen_idx5");

    // Clear beats load and shift in the same cycle.
    for (int k = 0; k < N; k++) bus.inp[k*DW +: DW] = 8'h55;
    bus.load = 1'b1; bus.shift = 1'b1; bus.clear = 1'b1;
    bus.col_in = {ROWS{8'h66}};
    tick();
    bus.load = 1'b0; bus.shift = 1'b0; bus.clear = 1'b0;
    for (int k = 0; k < N; k++) read_at(k, 0, "prio_outp");
    check("prio_full", 32'(bus.full), 0);

    // Back-to-back streams, then async reset at element 7 of the second.
    load_ramp();
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    for (int k = 1; k < N; k++) tick();
    check("b2b_last1", 32'(bus.stream_last), 1);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    check("b2b_valid", 32'(bus.stream_valid), 1);
    check("b2b_data0", 32'(bus.stream_data), 1);
    check("b2b_last0", 32'(bus.stream_last), 0);
    check("b2b_busy", 32'(bus.busy), 1);
    for (int k = 1; k <= 7; k++) tick();
    check("b2b_data7", 32'(bus.stream_data), 8);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.stream_valid), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_data", 32'(bus.stream_data), 0);
    check("arst_last", 32'(bus.stream_last), 0);
    read_at(0, 0, "arst_idx0");
    read_at(10, 0, "arst_idx10");
    read_at(15, 0, "arst_idx15");
    tick();
    rst = 1'b1;
    last_seen = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (bus.stream_last || bus.stream_valid) last_seen++;
    end
    check("arst_no_last", 32'(last_seen), 0);
    check("arst_full", 32'(bus.full), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
